// File: rtl/fifo_uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fifo_uart_pkg
// Description : Shared constants and state encodings for the FIFO-fed UART
//               transmitter.
// Revision    : 1.0 - initial release
// ============================================================================
package fifo_uart_pkg;

  // Default bit period in clk cycles (100 MHz / 115200 baud).
  localparam int CLKS_PER_BIT_DEF = 868;

  // 3-bit state encodings.
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_FETCH = 3'd1;
  localparam logic [2:0] ST_LOAD  = 3'd2;
  localparam logic [2:0] ST_START = 3'd3;
  localparam logic [2:0] ST_DATA  = 3'd4;
  localparam logic [2:0] ST_STOP  = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE  = ST_IDLE,
    S_FETCH = ST_FETCH,
    S_LOAD  = ST_LOAD,
    S_START = ST_START,
    S_DATA  = ST_DATA,
    S_STOP  = ST_STOP
  } state_t;

endpackage
`default_nettype wire

// File: rtl/uart_baud_gen.sv
`default_nettype none
// ============================================================================
// Module      : uart_baud_gen
// Description : Bit-period counter. Counts 0..CLKS_PER_BIT-1 and flags the
//               terminal count; held at zero while clear is high.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_baud_gen
  import fifo_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int             CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] TERM = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Terminal-count flag and wrap/clear next-count logic.
  always_comb begin
    tick  = (cnt_q == TERM);
    cnt_d = cnt_q + 1'b1;
    if (clear || tick) begin
      cnt_d = '0;
    end
  end

  // Counter register, asynchronously cleared by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/fifo_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : fifo_uart_tx
// Description : UART transmitter that pulls bytes from an upstream FIFO and
//               serialises them as 8N1/8N2 frames. All outputs registered.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_uart_tx
  import fifo_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_data,
  output logic       fifo_rd,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);

  state_t     state_q, state_d;
  logic [7:0] shift_q, shift_d;
  logic [2:0] bit_idx_q, bit_idx_d;
  logic       tx_q, tx_d;
  logic       fifo_rd_q, fifo_rd_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       baud_clear;
  logic       baud_tick;

  // Bit timer runs only in the timed states, so each timed state starts at 0.
  always_comb begin
    baud_clear = !((state_q == S_START) || (state_q == S_DATA) || (state_q == S_STOP));
  end

  uart_baud_gen #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud (
    .clk   (clk),
    .rst   (rst),
    .clear (baud_clear),
    .tick  (baud_tick)
  );

  // Next-state and next-output logic; outputs are derived from the next state.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_idx_d = bit_idx_q;
    tx_d      = 1'b1;
    done_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (en && !fifo_empty) begin
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        state_d = S_LOAD;
      end
      S_LOAD: begin
        // FIFO data is valid now, one cycle after the read strobe.
        state_d = S_START;
        shift_d = fifo_data;
        tx_d    = 1'b0;
      end
      S_START: begin
        tx_d = 1'b0;
        if (baud_tick) begin
          state_d = S_DATA;
          tx_d    = shift_q[0];
          shift_d = {1'b0, shift_q[7:1]};
        end
      end
      S_DATA: begin
        tx_d = tx_q;
        if (baud_tick) begin
          if (bit_idx_q == 3'd7) begin
            state_d   = S_STOP;
            tx_d      = 1'b1;
            bit_idx_d = 3'd0;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            tx_d      = shift_q[0];
            shift_d   = {1'b0, shift_q[7:1]};
          end
        end
      end
      S_STOP: begin
        if (baud_tick) begin
          if (bit_idx_q == LAST_STOP) begin
            state_d   = S_IDLE;
            bit_idx_d = 3'd0;
            done_d    = 1'b1;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    fifo_rd_d = (state_d == S_FETCH);
    busy_d    = (state_d != S_IDLE);
  end

  // State and registered outputs, all forced to idle values by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      shift_q   <= 8'h00;
      bit_idx_q <= 3'd0;
      tx_q      <= 1'b1;
      fifo_rd_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_idx_q <= bit_idx_d;
      tx_q      <= tx_d;
      fifo_rd_q <= fifo_rd_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign tx      = tx_q;
  assign fifo_rd = fifo_rd_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule
`default_nettype wire

// File: tb/tb_fifo_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_uart_tx
// Description : Self-checking bench: FIFO model, line decoder and scoreboard
//               for fifo_uart_tx (4 clocks per bit, 1 and 2 stop bits).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_uart_tx;

  localparam int CPB   = 4;
  localparam int FRAME = 10 * CPB;   // start + 8 data + 1 stop

  typedef struct {
    logic [7:0] data;
    bit         ok;
    int         st;
    int         dn;
  } rec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       fifo_empty;
  logic [7:0] fifo_data;
  logic       fifo_rd, tx, busy, done;

  logic       fifo2_empty;
  logic [7:0] fifo2_data;
  logic       rd2, tx2, busy2, done2;

  int         cyc = 0;
  int         n_cmp = 0;
  int         n_fail = 0;
  int         rd_count = 0;
  int         rd2_count = 0;
  int         done_count = 0;
  int         tx_low_cnt = 0;
  int         underflow = 0;
  int         rst_evt = 0;
  int         aborts = 0;

  logic [7:0] fifo_q[$];
  logic [7:0] exp_q[$];
  rec_t       mon_q[$];

  fifo_uart_tx #(.CLKS_PER_BIT(CPB), .STOP_BITS(1)) dut (
    .clk(clk), .rst(rst), .en(en), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
    .fifo_rd(fifo_rd), .tx(tx), .busy(busy), .done(done)
  );

  fifo_uart_tx #(.CLKS_PER_BIT(CPB), .STOP_BITS(2)) dut2 (
    .clk(clk), .rst(rst), .en(en), .fifo_empty(fifo2_empty), .fifo_data(fifo2_data),
    .fifo_rd(rd2), .tx(tx2), .busy(busy2), .done(done2)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge rst) rst_evt++;

  // Upstream FIFO model: data appears the cycle after the read strobe.
  always @(posedge clk) begin
    if (fifo_rd) begin
      if (fifo_q.size() > 0) fifo_data = fifo_q.pop_front();
      else underflow++;
      fifo_empty = (fifo_q.size() == 0);
    end
  end

  always @(negedge clk) begin
    if (fifo_rd) rd_count++;
    if (rd2) rd2_count++;
    if (done) done_count++;
    if (!tx) tx_low_cnt++;
  end

  // Line decoder: rebuilds each frame from the serial waveform.
  initial begin : p_mon
    logic       prev;
    int         ev, st, k, dn;
    logic [7:0] b;
    bit         ok, ab;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (prev && (tx === 1'b0) && !rst) begin
        ev = rst_evt; st = cyc; ok = 1'b1; ab = 1'b0; b = 8'h00;
        for (int i = 0; i < FRAME; i++) begin
          if (i > 0) @(negedge clk);
          if (rst_evt != ev) begin ab = 1'b1; break; end
          k = i / CPB;
          if (k >= 1 && k <= 8) begin
            if (i % CPB == 0) b[k-1] = tx;
            else if (tx !== b[k-1]) ok = 1'b0;
          end else if (tx !== ((k == 0) ? 1'b0 : 1'b1)) begin
            ok = 1'b0;
          end
          if (done !== 1'b0) ok = 1'b0;
        end
        if (ab) begin
          aborts++;
        end else begin
          @(negedge clk);
          dn = (done === 1'b1) ? cyc : -1;
          mon_q.push_back('{data: b, ok: ok, st: st, dn: dn});
        end
      end
      prev = tx;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] v);
    fifo_q.push_back(v);
    exp_q.push_back(v);
    fifo_empty = 1'b0;
  endtask

  task automatic wait_mon(input int n, input int bound);
    for (int i = 0; i < bound && mon_q.size() < n; i++) @(negedge clk);
    chk("mon_timeout", mon_q.size(), n);
  endtask

  task automatic wait_tx_low(input int bound);
    for (int i = 0; i < bound && tx !== 1'b0; i++) @(negedge clk);
    chk("tx_fall_timeout", tx, 1'b0);
  endtask

  initial begin : p_watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : p_main
    int         n, base, rd0, s, dc0, s2, hi, len;
    logic [7:0] c;
    rec_t       r;
    logic       t2 [0:79];

    // Reset values before the first clock edge.
    rst = 1'b1; en = 1'b0; fifo_empty = 1'b1; fifo_data = 8'h00;
    fifo2_empty = 1'b1; fifo2_data = 8'hFF;
    #1;
    chk("rst_tx", tx, 1'b1);
    chk("rst_fifo_rd", fifo_rd, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Enable low with data waiting: nothing is fetched or sent.
    push(8'hA5);
    n = tx_low_cnt;
    repeat (20) @(negedge clk);
    chk("en0_rd", rd_count, 0);
    chk("en0_tx_quiet", tx_low_cnt - n, 0);
    chk("en0_busy", busy, 1'b0);

    // Single byte 0xA5.
    en = 1'b1;
    n = cyc;
    wait_mon(1, 80);
    r = mon_q[0];
    chk("a5_data", r.data, exp_q.pop_front());
    chk("a5_shape", r.ok, 1'b1);
    chk("a5_start_latency", r.st - n, 3);
    chk("a5_done_offset", r.dn - r.st, FRAME);
    repeat (5) @(negedge clk);
    chk("a5_idle_busy", busy, 1'b0);
    chk("a5_rd_count", rd_count, 1);

    // Back-to-back bytes: 01, 02, 03 plus random bytes.
    base = mon_q.size(); rd0 = rd_count;
    push(8'h01); push(8'h02); push(8'h03);
    for (int i = 0; i < 3; i++) push(8'($urandom));
    wait_mon(base + 6, 400);
    for (int i = 0; i < 6; i++) begin
      r = mon_q[base + i];
      chk($sformatf("b2b_data%0d", i), r.data, exp_q.pop_front());
      chk($sformatf("b2b_shape%0d", i), r.ok, 1'b1);
      if (i > 0) chk($sformatf("b2b_gap%0d", i), r.st - mon_q[base + i - 1].dn, 3);
    end
    chk("b2b_rd_count", rd_count - rd0, 6);

    // Enable dropped during the data bits: frame completes, no further reads.
    base = mon_q.size(); rd0 = rd_count;
    push(8'($urandom)); push(8'($urandom));
    wait_tx_low(20);
    repeat (10) @(negedge clk);
    en = 1'b0;
    wait_mon(base + 1, 100);
    r = mon_q[base];
    chk("endrop_data", r.data, exp_q.pop_front());
    chk("endrop_shape", r.ok, 1'b1);
    chk("endrop_done", r.dn - r.st, FRAME);
    repeat (60) @(negedge clk);
    chk("endrop_no_more_frames", mon_q.size(), base + 1);
    chk("endrop_rd_count", rd_count - rd0, 1);

    // Reset during data bit 3: frame abandoned, next byte sent whole.
    base = mon_q.size(); rd0 = rd_count;
    c = 8'($urandom);
    push(c);
    en = 1'b1;
    wait_tx_low(20);
    s = cyc;
    repeat (17) @(negedge clk);
    dc0 = done_count;
    rst = 1'b1;
    #1;
    chk("midrst_tx", tx, 1'b1);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_bitpos", cyc - s, 17);
    repeat (3) @(negedge clk);
    chk("midrst_no_done", done_count, dc0);
    rst = 1'b0;
    void'(exp_q.pop_front());
    wait_mon(base + 1, 100);
    r = mon_q[base];
    chk("midrst_next_data", r.data, c);
    chk("midrst_next_shape", r.ok, 1'b1);
    chk("midrst_rd_count", rd_count - rd0, 2);
    chk("midrst_abort_seen", aborts, 1);

    // Two stop bits, byte 0xFF: 44-cycle frame, final 8 cycles high.
    fifo2_empty = 1'b0;
    for (int i = 0; i < 10 && rd2 !== 1'b1; i++) @(negedge clk);
    chk("sb2_rd", rd2, 1'b1);
    fifo2_empty = 1'b1;
    for (int i = 0; i < 10 && tx2 !== 1'b0; i++) @(negedge clk);
    chk("sb2_tx_fall", tx2, 1'b0);
    s2 = cyc; len = 0;
    for (int i = 0; i < 80 && done2 !== 1'b1; i++) begin
      t2[i] = tx2;
      len++;
      @(negedge clk);
    end
    chk("sb2_frame_len", cyc - s2, 44);
    hi = 0;
    for (int i = 4; i < 44 && i < len; i++) if (t2[i] === 1'b1) hi++;
    chk("sb2_high_after_start", hi, 40);
    hi = 0;
    for (int i = 36; i < 44 && i < len; i++) if (t2[i] === 1'b1) hi++;
    chk("sb2_last8_high", hi, 8);
    chk("sb2_rd_count", rd2_count, 1);

    chk("no_underflow", underflow, 0);
    chk("no_extra_frames", mon_q.size(), base + 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
